// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: stall/flush vectors, forwarding, memory-wait FSM.
// Optional operand forwarding enabled by defining HAZ_FWD_EN; otherwise a full RAW interlock.
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int MEM_TMO  = 16,
  parameter int BR_FLUSH = 2,
  parameter int CNT_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs1_use,
  input  logic              i_id_rs2_use,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_wr_en,
  input  logic              i_ex_is_load,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_wr_en,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_wr_en,
  input  logic              i_branch_taken,
  input  logic              i_mem_req,
  input  logic              i_mem_ack,
  input  logic              i_ex_multi,
  input  logic              i_ex_done,
  output logic [4:0]        o_stall,
  output logic [4:0]        o_flush,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_mem_tmo,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_EX_BUSY  = 2'd2
  } state_t;

  localparam logic [4:0] BR_MASK =
    (BR_FLUSH == 3) ? 5'b00111 : 5'b00011;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  logic w_mem_wait;
  logic w_ex_busy;
  logic w_tmo;
  logic w_load_use;
  logic w_raw;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  function automatic logic f_hit(
    input logic [REG_AW-1:0] rd,
    input logic              we,
    input logic [REG_AW-1:0] rs,
    input logic              rd_en
  );
    return rd_en && we && (rd != '0) && (rd == rs);
  endfunction

  assign w_mem_wait = i_mem_req && !i_mem_ack;
  assign w_ex_busy  = i_ex_multi && !i_ex_done;
  assign w_cnt_inc  = r_cnt + 1'b1;

  // Timeout fires on the MEM_TMO-th consecutive unacked cycle.
  assign w_tmo = (r_state == ST_MEM_WAIT) && w_mem_wait &&
                 (w_cnt_inc == CNT_W'(MEM_TMO));

  assign w_load_use = i_ex_is_load &&
    (f_hit(i_ex_rd, i_ex_wr_en, i_id_rs1, i_id_rs1_use) ||
     f_hit(i_ex_rd, i_ex_wr_en, i_id_rs2, i_id_rs2_use));

`ifdef HAZ_FWD_EN
  function automatic logic [1:0] f_fwd(input logic [REG_AW-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (i_mem_wr_en && (i_mem_rd == rs))
        sel = 2'b01;
      else if (i_wb_wr_en && (i_wb_rd == rs))
        sel = 2'b10;
    end
    return sel;
  endfunction

  assign w_fwd_a = f_fwd(i_id_rs1);
  assign w_fwd_b = f_fwd(i_id_rs2);
  assign w_raw   = w_load_use;
`else
  assign w_fwd_a = 2'b00;
  assign w_fwd_b = 2'b00;
  // Without bypass, ID waits until the producer has left WB.
  assign w_raw = w_load_use ||
    f_hit(i_ex_rd,  i_ex_wr_en,  i_id_rs1, i_id_rs1_use) ||
    f_hit(i_ex_rd,  i_ex_wr_en,  i_id_rs2, i_id_rs2_use) ||
    f_hit(i_mem_rd, i_mem_wr_en, i_id_rs1, i_id_rs1_use) ||
    f_hit(i_mem_rd, i_mem_wr_en, i_id_rs2, i_id_rs2_use) ||
    f_hit(i_wb_rd,  i_wb_wr_en,  i_id_rs1, i_id_rs1_use) ||
    f_hit(i_wb_rd,  i_wb_wr_en,  i_id_rs2, i_id_rs2_use);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    w_cnt_nxt   = '0;
    case (r_state)
      ST_MEM_WAIT: begin
        if (w_mem_wait && !w_tmo) begin
          w_state_nxt = ST_MEM_WAIT;
          w_cnt_nxt   = w_cnt_inc;
        end else if (!w_mem_wait && w_ex_busy) begin
          w_state_nxt = ST_EX_BUSY;
        end
      end
      ST_RUN, ST_EX_BUSY: begin
        if (w_mem_wait) begin
          w_state_nxt = ST_MEM_WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end else if (w_ex_busy) begin
          w_state_nxt = ST_EX_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    o_stall   = 5'b00000;
    o_flush   = 5'b00000;
    o_fwd_a   = w_fwd_a;
    o_fwd_b   = w_fwd_b;
    o_mem_tmo = 1'b0;
    if (i_rst) begin
      o_flush = 5'b11111;
      o_fwd_a = 2'b00;
      o_fwd_b = 2'b00;
    end else if (w_tmo) begin
      o_mem_tmo = 1'b1;
      o_flush   = 5'b01000;
    end else if (w_mem_wait) begin
      o_stall = 5'b01111;
      o_flush = 5'b10000;
    end else if (w_ex_busy) begin
      o_stall = 5'b00111;
      o_flush = 5'b01000;
    end else if (i_branch_taken) begin
      o_flush = BR_MASK;
    end else if (w_raw) begin
      o_stall = 5'b00011;
      o_flush = 5'b00100;
    end
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TMO=4, BR_FLUSH=2).
// Expectations follow the HAZ_FWD_EN setting of the build.
module tb_pipe_hazard_ctrl;

`ifdef HAZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, ex_rd, mem_rd, wb_rd;
  logic       rs1_use, rs2_use, ex_wr, ex_ld, mem_wr, wb_wr;
  logic       br, mreq, mack, emulti, edone;
  logic [4:0] stall, flush;
  logic [1:0] fwd_a, fwd_b, state;
  logic       tmo;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW(5), .MEM_TMO(4), .BR_FLUSH(2), .CNT_W(8)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_rs1_use(rs1_use), .i_id_rs2_use(rs2_use),
    .i_ex_rd(ex_rd), .i_ex_wr_en(ex_wr), .i_ex_is_load(ex_ld),
    .i_mem_rd(mem_rd), .i_mem_wr_en(mem_wr),
    .i_wb_rd(wb_rd), .i_wb_wr_en(wb_wr),
    .i_branch_taken(br),
    .i_mem_req(mreq), .i_mem_ack(mack),
    .i_ex_multi(emulti), .i_ex_done(edone),
    .o_stall(stall), .o_flush(flush),
    .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
    .o_mem_tmo(tmo), .o_state(state)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; rs1_use = 0; rs2_use = 0;
    ex_rd = '0; ex_wr = 0; ex_ld = 0;
    mem_rd = '0; mem_wr = 0; wb_rd = '0; wb_wr = 0;
    br = 0; mreq = 0; mack = 0; emulti = 0; edone = 0;
  endtask

  // Check all outputs at the falling edge, then step past the next rising edge.
  task automatic look(input string tag, input logic [4:0] e_st,
                      input logic [4:0] e_fl, input logic [1:0] e_fa,
                      input logic [1:0] e_fb, input logic e_tmo,
                      input logic [1:0] e_state);
    @(negedge clk);
    chk({tag, ".stall"}, {3'b0, stall}, {3'b0, e_st});
    chk({tag, ".flush"}, {3'b0, flush}, {3'b0, e_fl});
    chk({tag, ".fwd_a"}, {6'b0, fwd_a}, {6'b0, e_fa});
    chk({tag, ".fwd_b"}, {6'b0, fwd_b}, {6'b0, e_fb});
    chk({tag, ".tmo"},   {7'b0, tmo},   {7'b0, e_tmo});
    chk({tag, ".state"}, {6'b0, state}, {6'b0, e_state});
    @(posedge clk);
    #1;
  endtask

  logic [4:0] raw_st, raw_fl;

  initial begin
    idle();
    rst = 1;
    raw_st = FWD ? 5'b00000 : 5'b00011;
    raw_fl = FWD ? 5'b00000 : 5'b00100;
    @(posedge clk);
    #1;
    look("rst0", 5'b00000, 5'b11111, 2'b00, 2'b00, 0, 2'd0);
    look("rst1", 5'b00000, 5'b11111, 2'b00, 2'b00, 0, 2'd0);
    rst = 0;
    look("run", 5'b00000, 5'b00000, 2'b00, 2'b00, 0, 2'd0);

    // forwarding / RAW against MEM and WB producers
    mem_rd = 5; mem_wr = 1; rs1 = 5; rs1_use = 1;
    look("fwd_mem", raw_st, raw_fl, FWD ? 2'b01 : 2'b00, 2'b00, 0, 2'd0);
    idle();
    wb_rd = 5; wb_wr = 1; rs1 = 5; rs1_use = 1;
    look("fwd_wb", raw_st, raw_fl, FWD ? 2'b10 : 2'b00, 2'b00, 0, 2'd0);
    idle();
    mem_rd = 0; mem_wr = 1; rs1 = 0; rs1_use = 1;
    look("fwd_x0", 5'b00000, 5'b00000, 2'b00, 2'b00, 0, 2'd0);
    idle();
    wb_rd = 5; wb_wr = 0; rs1 = 5; rs1_use = 1;
    look("fwd_nowr", 5'b00000, 5'b00000, 2'b00, 2'b00, 0, 2'd0);
    idle();
    mem_rd = 6; mem_wr = 1; wb_rd = 6; wb_wr = 1; rs2 = 6; rs2_use = 1;
    look("fwd_prio", raw_st, raw_fl, 2'b00, FWD ? 2'b01 : 2'b00, 0, 2'd0);

    // load-use
    idle();
    ex_rd = 7; ex_wr = 1; ex_ld = 1; rs2 = 7; rs2_use = 1;
    look("lu", 5'b00011, 5'b00100, 2'b00, 2'b00, 0, 2'd0);
    idle();
    mem_rd = 7; mem_wr = 1; rs2 = 7; rs2_use = 1;
    look("lu_next", raw_st, raw_fl, 2'b00, FWD ? 2'b01 : 2'b00, 0, 2'd0);
    idle();
    ex_rd = 7; ex_wr = 1; ex_ld = 1; rs2 = 7; rs2_use = 0;
    look("lu_nouse", 5'b00000, 5'b00000, 2'b00, 2'b00, 0, 2'd0);
    idle();
    ex_rd = 7; ex_wr = 1; ex_ld = 1; rs2 = 7; rs2_use = 1; br = 1;
    look("lu_br", 5'b00000, 5'b00011, 2'b00, 2'b00, 0, 2'd0);

    // memory wait, acked on the fourth cycle
    idle();
    mreq = 1;
    look("mw1", 5'b01111, 5'b10000, 2'b00, 2'b00, 0, 2'd0);
    look("mw2", 5'b01111, 5'b10000, 2'b00, 2'b00, 0, 2'd1);
    look("mw3", 5'b01111, 5'b10000, 2'b00, 2'b00, 0, 2'd1);
    mack = 1;
    look("mw_ack", 5'b00000, 5'b00000, 2'b00, 2'b00, 0, 2'd1);
    idle();
    look("mw_done", 5'b00000, 5'b00000, 2'b00, 2'b00, 0, 2'd0);

    // memory timeout
    mreq = 1;
    look("to1", 5'b01111, 5'b10000, 2'b00, 2'b00, 0, 2'd0);
    look("to2", 5'b01111, 5'b10000, 2'b00, 2'b00, 0, 2'd1);
    look("to3", 5'b01111, 5'b10000, 2'b00, 2'b00, 0, 2'd1);
    look("to4", 5'b00000, 5'b01000, 2'b00, 2'b00, 1, 2'd1);
    idle();
    look("to_after", 5'b00000, 5'b00000, 2'b00, 2'b00, 0, 2'd0);

    // multicycle EX with a pending taken branch
    emulti = 1; br = 1;
    look("ex1", 5'b00111, 5'b01000, 2'b00, 2'b00, 0, 2'd0);
    for (int i = 2; i <= 5; i++)
      look("exN", 5'b00111, 5'b01000, 2'b00, 2'b00, 0, 2'd2);
    edone = 1;
    look("ex_done_br", 5'b00000, 5'b00011, 2'b00, 2'b00, 0, 2'd2);
    idle();
    look("ex_after", 5'b00000, 5'b00000, 2'b00, 2'b00, 0, 2'd0);

    // memory wait arising during EX busy
    emulti = 1;
    look("exm1", 5'b00111, 5'b01000, 2'b00, 2'b00, 0, 2'd0);
    mreq = 1;
    look("exm2", 5'b01111, 5'b10000, 2'b00, 2'b00, 0, 2'd2);
    look("exm3", 5'b01111, 5'b10000, 2'b00, 2'b00, 0, 2'd1);
    mack = 1;
    look("exm_ack", 5'b00111, 5'b01000, 2'b00, 2'b00, 0, 2'd1);
    idle();
    look("exm_idle", 5'b00000, 5'b00000, 2'b00, 2'b00, 0, 2'd2);
    look("exm_run", 5'b00000, 5'b00000, 2'b00, 2'b00, 0, 2'd0);

    // back-to-back RAW on an ALU result
    ex_rd = 5; ex_wr = 1; rs1 = 5; rs1_use = 1;
    look("raw1", raw_st, raw_fl, 2'b00, 2'b00, 0, 2'd0);
    idle();
    mem_rd = 5; mem_wr = 1; rs1 = 5; rs1_use = 1;
    look("raw2", raw_st, raw_fl, FWD ? 2'b01 : 2'b00, 2'b00, 0, 2'd0);
    idle();
    wb_rd = 5; wb_wr = 1; rs1 = 5; rs1_use = 1;
    look("raw3", raw_st, raw_fl, FWD ? 2'b10 : 2'b00, 2'b00, 0, 2'd0);
    idle();
    rs1 = 5; rs1_use = 1;
    look("raw4", 5'b00000, 5'b00000, 2'b00, 2'b00, 0, 2'd0);

    // reset in the middle of a memory wait
    idle();
    mreq = 1;
    look("rm1", 5'b01111, 5'b10000, 2'b00, 2'b00, 0, 2'd0);
    look("rm2", 5'b01111, 5'b10000, 2'b00, 2'b00, 0, 2'd1);
    rst = 1;
    look("rm_rst", 5'b00000, 5'b11111, 2'b00, 2'b00, 0, 2'd1);
    rst = 0;
    idle();
    look("rm_after", 5'b00000, 5'b00000, 2'b00, 2'b00, 0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
